// File: rtl/ahb_decoder_mux_n.sv
// rtl/ahb_decoder_mux_n.sv - AHB-Lite address decoder and response mux with default slave and wait watchdog
//
// Purpose: decodes the master address into a one-hot slave select, tracks the
// data-phase owner across wait states, and muxes the owner's response back to
// the master. Unmapped active transfers and slaves that stall longer than
// TIMEOUT cycles are answered with a two-cycle ERROR by an internal default slave.
//
// Ports:
//   i_hclk, i_hreset          clock, synchronous active-high reset
//   i_m_haddr, i_m_htrans     master address phase
//   o_m_hrdata, o_m_hresp,
//   o_m_hready                muxed response to master (hready also goes to slaves)
//   o_s_hsel                  one-hot address-phase slave select
//   i_s_hrdata, i_s_hresp,
//   i_s_hreadyout             packed per-slave responses
//   o_dec_err                 pulse on the first cycle of a decoder ERROR
//   o_err_addr                address of the last errored transfer
module ahb_decoder_mux_n #(
    parameter int                           NUM_SLV    = 4,
    parameter int                           ADDR_W     = 32,
    parameter int                           DATA_W     = 32,
    parameter logic [ADDR_W*NUM_SLV-1:0]    BASE_ADDRS = '0,
    parameter logic [ADDR_W-1:0]            ADDR_MASK  = ADDR_W'(32'hFFFF_F000),
    parameter int                           TIMEOUT    = 16
) (
    input  logic                        i_hclk,
    input  logic                        i_hreset,
    input  logic [ADDR_W-1:0]           i_m_haddr,
    input  logic [1:0]                  i_m_htrans,
    output logic [DATA_W-1:0]           o_m_hrdata,
    output logic [1:0]                  o_m_hresp,
    output logic                        o_m_hready,
    output logic [NUM_SLV-1:0]          o_s_hsel,
    input  logic [DATA_W*NUM_SLV-1:0]   i_s_hrdata,
    input  logic [2*NUM_SLV-1:0]        i_s_hresp,
    input  logic [NUM_SLV-1:0]          i_s_hreadyout,
    output logic                        o_dec_err,
    output logic [ADDR_W-1:0]           o_err_addr
);

    localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

    state_t                 r_state;
    logic                   r_dsel_def;     // data phase owned by the default slave
    logic [IDX_W-1:0]       r_dsel_idx;
    logic                   r_dactive;
    logic [ADDR_W-1:0]      r_haddr;        // address of the transfer now in data phase
    logic [WCNT_W-1:0]      r_wcnt;
    logic [ADDR_W-1:0]      r_err_addr;

    logic                   w_hit;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_active;
    logic                   w_unmapped;
    logic                   w_slv_rdy;
    logic                   w_wait;

    // Scan from the top so the lowest matching index wins on overlap.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        o_s_hsel  = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((i_m_haddr & ADDR_MASK) == BASE_ADDRS[i*ADDR_W +: ADDR_W]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
        if (w_hit) begin
            o_s_hsel[w_hit_idx] = 1'b1;
        end
    end

    assign w_active   = (i_m_htrans == 2'b10) || (i_m_htrans == 2'b11);
    assign w_unmapped = w_active && !w_hit;
    assign w_slv_rdy  = i_s_hreadyout[r_dsel_idx];
    assign w_wait     = (TIMEOUT != 0) && (r_state == ST_IDLE) && r_dactive
                        && !r_dsel_def && !w_slv_rdy;

    // Error states override the slave mux; the default slave never returns data.
    always_comb begin
        o_m_hrdata = '0;
        o_m_hresp  = 2'b00;
        o_m_hready = 1'b1;
        case (r_state)
            ST_ERR1: begin
                o_m_hready = 1'b0;
                o_m_hresp  = 2'b01;
            end
            ST_ERR2: begin
                o_m_hresp  = 2'b01;
            end
            default: begin
                if (!r_dsel_def) begin
                    o_m_hrdata = i_s_hrdata[r_dsel_idx*DATA_W +: DATA_W];
                    o_m_hresp  = i_s_hresp[r_dsel_idx*2 +: 2];
                    o_m_hready = w_slv_rdy;
                end
            end
        endcase
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state    <= ST_IDLE;
            r_dsel_def <= 1'b1;
            r_dsel_idx <= '0;
            r_dactive  <= 1'b0;
            r_haddr    <= '0;
            r_wcnt     <= '0;
            r_err_addr <= '0;
        end else begin
            if (o_m_hready) begin
                r_dsel_def <= !w_hit;
                r_dsel_idx <= w_hit_idx;
                r_dactive  <= w_active;
                r_haddr    <= i_m_haddr;
                r_wcnt     <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (o_m_hready && w_unmapped) begin
                        r_state    <= ST_ERR1;
                        r_err_addr <= i_m_haddr;
                    end else if (w_wait) begin
                        // Abort the stalled slave: hand the data phase to the
                        // default slave so its outputs are ignored from now on.
                        if (r_wcnt == WCNT_LAST) begin
                            r_state    <= ST_ERR1;
                            r_err_addr <= r_haddr;
                            r_dsel_def <= 1'b1;
                        end
                        if (r_wcnt != WCNT_MAX) begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                ST_ERR1: r_state <= ST_ERR2;
                ST_ERR2: begin
                    // Ready is high here, so the next transfer is being accepted.
                    if (w_unmapped) begin
                        r_state    <= ST_ERR1;
                        r_err_addr <= i_m_haddr;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_dec_err  = (r_state == ST_ERR1);
    assign o_err_addr = r_err_addr;

endmodule
